// File: rtl/iir_biquad_sequencer.sv
// iir_biquad_sequencer
// Time-multiplexed direct-form-I biquad controller. It presents one
// coefficient/data pair per cycle to an external combinational sign-magnitude
// Q7.8 multiplier, accumulates the returned products, saturates the sum and
// emits one filtered sample. It also holds the x/y delay lines.
//
// state | meaning
// IDLE  | ready=1, multiplier operands forced to 0, waiting for a sample
// MAC   | term k (0..4) on the multiplier, product accumulated each edge
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sample_in/_valid      input sample x[n] and its valid flag
//   ready                 high in IDLE; accept on sample_valid && ready
//   b0,b1,b2,a1,a2        coefficients (sign-magnitude Q7.8)
//   mult_a, mult_b        coefficient and data operands to the multiplier
//   mult_p                saturated multiplier product (same cycle)
//   y_out, y_valid        filtered sample and its one-cycle strobe
module iir_biquad_sequencer #(
  parameter int NTAPS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        ready,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  input  logic [15:0] b2,
  input  logic [15:0] a1,
  input  logic [15:0] a2,
  output logic [15:0] mult_a,
  output logic [15:0] mult_b,
  input  logic [15:0] mult_p,
  output logic [15:0] y_out,
  output logic        y_valid
);

  localparam logic [2:0] KLAST = 3'(NTAPS - 1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t             state, state_nxt;
  logic [2:0]         k;
  logic [15:0]        x, x1, x2, y1, y2;
  logic signed [18:0] acc;
  logic signed [18:0] term;
  logic signed [18:0] sum;
  logic signed [18:0] neg;
  logic [18:0]        mag;
  logic               term_neg;
  logic [15:0]        y_sat;

  assign ready = (state == IDLE);

  // operand decode; IDLE keeps the multiplier inputs quiet
  always_comb begin
    mult_a = 16'h0000;
    mult_b = 16'h0000;
    if (state == MAC) begin
      case (k)
        3'd0:    begin mult_a = b0; mult_b = x;  end
        3'd1:    begin mult_a = b1; mult_b = x1; end
        3'd2:    begin mult_a = b2; mult_b = x2; end
        3'd3:    begin mult_a = a1; mult_b = y1; end
        3'd4:    begin mult_a = a2; mult_b = y2; end
        default: begin mult_a = 16'h0000; mult_b = 16'h0000; end
      endcase
    end
  end

  // feedback terms are subtracted by flipping the product sign;
  // negative zero falls out as 0 because only the magnitude is negated
  always_comb begin
    term_neg = mult_p[15] ^ (k >= 3'd3);
    mag      = {4'b0000, mult_p[14:0]};
    term     = term_neg ? -$signed(mag) : $signed(mag);
    sum      = acc + term;
    neg      = -sum;
    if (sum > 19'sd32767)
      y_sat = 16'h7FFF;
    else if (sum < -19'sd32767)
      y_sat = 16'hFFFF;
    else if (sum == 19'sd0)
      y_sat = 16'h0000;
    else if (sum < 19'sd0)
      y_sat = {1'b1, neg[14:0]};
    else
      y_sat = {1'b0, sum[14:0]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid) state_nxt = MAC;
      MAC:     if (k == KLAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= 3'd0;
      acc     <= '0;
      x       <= 16'h0000;
      x1      <= 16'h0000;
      x2      <= 16'h0000;
      y1      <= 16'h0000;
      y2      <= 16'h0000;
      y_out   <= 16'h0000;
      y_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            x   <= sample_in;
            acc <= '0;
            k   <= 3'd0;
          end
        end
        MAC: begin
          acc <= sum;
          if (k == KLAST) begin
            k       <= 3'd0;
            y_out   <= y_sat;
            y_valid <= 1'b1;
            x2      <= x1;
            x1      <= x;
            y2      <= y1;
            y1      <= y_sat;
          end else begin
            k <= k + 3'd1;
          end
        end
        default: k <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// tb_iir_biquad_sequencer
// Bench for iir_biquad_sequencer with a behavioural sign-magnitude Q7.8
// multiplier in the loop, a sample-level reference model of the filter, a
// per-cycle compare process and a set of directed literal checks.
module tb_iir_biquad_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        ready;
  logic [15:0] b0 = 16'h0000, b1 = 16'h0000, b2 = 16'h0000;
  logic [15:0] a1 = 16'h0000, a2 = 16'h0000;
  logic [15:0] mult_a, mult_b, mult_p;
  logic [15:0] y_out;
  logic        y_valid;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  iir_biquad_sequencer #(.NTAPS(5)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in),
    .sample_valid(sample_valid), .ready(ready),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .y_out(y_out), .y_valid(y_valid)
  );

  // sign-magnitude Q7.8 multiply, truncated and saturated
  function automatic logic [15:0] smul(input logic [15:0] a, input logic [15:0] b);
    int unsigned m;
    m = (int'(a[14:0]) * int'(b[14:0])) >> 8;
    if (m > 32767) m = 32767;
    if (m == 0) return 16'h0000;
    return {a[15] ^ b[15], m[14:0]};
  endfunction

  always_comb mult_p = smul(mult_a, mult_b);

  function automatic int sm2i(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  function automatic logic [15:0] i2sm_sat(input int s);
    int n;
    if (s > 32767) return 16'h7FFF;
    if (s < -32767) return 16'hFFFF;
    if (s == 0) return 16'h0000;
    if (s < 0) begin
      n = -s;
      return {1'b1, n[14:0]};
    end
    return {1'b0, s[14:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          busy = 0;          // MAC cycles left, 0 = idle
  logic [15:0] px = 0, mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  logic [15:0] exp_y = 0;
  logic        exp_yv = 0;

  function automatic logic [15:0] filt(input logic [15:0] xn);
    int s;
    s = sm2i(smul(b0, xn)) + sm2i(smul(b1, mx1)) + sm2i(smul(b2, mx2))
      - sm2i(smul(a1, my1)) - sm2i(smul(a2, my2));
    return i2sm_sat(s);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      busy <= 0; exp_y <= 0; exp_yv <= 0;
      mx1 <= 0; mx2 <= 0; my1 <= 0; my2 <= 0;
    end else begin
      exp_yv <= 1'b0;
      if (busy == 0) begin
        if (sample_valid) begin
          busy <= 5;
          px   <= sample_in;
        end
      end else begin
        busy <= busy - 1;
        if (busy == 1) begin
          exp_y  <= filt(px);
          exp_yv <= 1'b1;
          my1 <= filt(px); my2 <= my1;
          mx1 <= px;       mx2 <= mx1;
        end
      end
    end
  end

  logic [15:0] exp_ma, exp_mb;
  always_comb begin
    exp_ma = 16'h0000;
    exp_mb = 16'h0000;
    case (busy)
      5: begin exp_ma = b0; exp_mb = px;  end
      4: begin exp_ma = b1; exp_mb = mx1; end
      3: begin exp_ma = b2; exp_mb = mx2; end
      2: begin exp_ma = a1; exp_mb = my1; end
      1: begin exp_ma = a2; exp_mb = my2; end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",   ready,   busy == 0);
      chk("y_valid", y_valid, exp_yv);
      chk("y_out",   y_out,   exp_y);
      chk("mult_a",  mult_a,  exp_ma);
      chk("mult_b",  mult_b,  exp_mb);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_coef(input logic [15:0] c0, c1, c2, c3, c4);
    b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
  endtask

  task automatic run_sample(input logic [15:0] xs, output logic [15:0] y);
    int i;
    for (i = 0; i < 20 && !ready; i++) step();
    sample_in = xs; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("ready_low_T1", ready, 1'b0);
    for (i = 0; i < 12 && !y_valid; i++) step();
    chk("latency", i, 5);
    y = y_out;
  endtask

  initial begin
    logic [15:0] y;
    int last, npulse;
    bit seen;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_y_out", y_out, 16'h0000);
    chk("rst_y_valid", y_valid, 1'b0);

    // pass-through
    set_coef(16'h0100, 0, 0, 0, 0);
    run_sample(16'h0280, y); chk("pass", y, 16'h0280);

    // recursive impulse
    do_reset();
    set_coef(16'h0100, 0, 0, 16'h8080, 0);
    run_sample(16'h0100, y); chk("imp0", y, 16'h0100);
    run_sample(16'h0000, y); chk("imp1", y, 16'h0080);
    run_sample(16'h0000, y); chk("imp2", y, 16'h0040);

    // saturation, both signs
    do_reset();
    set_coef(16'h0400, 16'h0400, 0, 0, 0);
    run_sample(16'h1000, y); chk("satp0", y, 16'h4000);
    run_sample(16'h1000, y); chk("satp1", y, 16'h7FFF);
    do_reset();
    run_sample(16'h9000, y); chk("satn0", y, 16'hC000);
    run_sample(16'h9000, y); chk("satn1", y, 16'hFFFF);

    // sign and zero
    do_reset();
    set_coef(16'h0100, 0, 0, 0, 0);
    run_sample(16'h8000, y); chk("negzero", y, 16'h0000);
    run_sample(16'h8180, y); chk("neg", y, 16'h8180);

    // reset at k=2 aborts and clears history
    do_reset();
    set_coef(16'h0100, 0, 0, 16'h8080, 0);
    run_sample(16'h0100, y);
    sample_in = 16'h0100; sample_valid = 1'b1;
    step();                 // now in T+1, k=0
    sample_valid = 1'b0;
    step(); step();         // T+3, k=2
    reset = 1'b1;
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (y_valid) seen = 1'b1;
      step();
    end
    chk("abort_no_yv", seen, 1'b0);
    run_sample(16'h0100, y); chk("post_rst0", y, 16'h0100);
    run_sample(16'h0000, y); chk("post_rst1", y, 16'h0080);

    // back-to-back with sample_valid held high
    do_reset();
    set_coef(16'h0100, 0, 0, 0, 0);
    sample_valid = 1'b1;
    last = -1; npulse = 0;
    for (int c = 0; c < 40; c++) begin
      sample_in = 16'($urandom);
      step();
      if (y_valid) begin
        if (last >= 0) chk("b2b_spacing", c - last, 6);
        last = c; npulse++;
      end
    end
    sample_valid = 1'b0;
    chk("b2b_count", npulse, 6);

    // randomized traffic with occasional coefficient changes and resets
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (ready && $urandom_range(3) == 0)
        set_coef({1'($urandom), 15'($urandom_range(16'h0300))},
                 {1'($urandom), 15'($urandom_range(16'h0300))},
                 {1'($urandom), 15'($urandom_range(16'h0300))},
                 {1'($urandom), 15'($urandom_range(16'h00C0))},
                 {1'($urandom), 15'($urandom_range(16'h00C0))});
      sample_in    = ($urandom_range(7) == 0) ? 16'($urandom) :
                     {1'($urandom), 15'($urandom_range(16'h0800))};
      sample_valid = ($urandom_range(2) != 0);
      reset        = ($urandom_range(80) == 0);
      step();
    end
    reset = 1'b0; sample_valid = 1'b0;
    step(); step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
